// File: rtl/dtree_pkg.sv
// Shared definitions between the spike front end and the decision-tree classifier.
package dtree_pkg;

    localparam int IN_WIDTH = 10;
    localparam int FEATURES = 3;

    typedef logic signed [IN_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {ARMED, CAPTURE, EMIT, HOLD} state_t;

endpackage

// File: rtl/sample_history.sv
// Circular buffer of the last PRE accepted ADC samples, the previous-sample register
// and a fill counter that says when enough samples exist to judge a crossing.
module sample_history
    import dtree_pkg::*;
#(
    parameter int PRE = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [IN_WIDTH-1:0]     sample_i,
    output logic [PRE*IN_WIDTH-1:0] taps_o,
    output logic [IN_WIDTH-1:0]     prev_o,
    output logic                    full_o
);

    localparam int PTR_W = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int FILL_W = $clog2(PRE + 2);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PRE - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PRE + 1);

    logic [IN_WIDTH-1:0] ring_q [PRE];
    logic [PTR_W-1:0]    wptr_q;
    logic [FILL_W-1:0]   fill_q;
    logic [IN_WIDTH-1:0] prev_q;
    logic [PTR_W:0]      rdIdx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ring_q <= '{default: '0};
            wptr_q <= '0;
            fill_q <= '0;
            prev_q <= '0;
        end else if (push_i) begin
            ring_q[wptr_q] <= sample_i;
            wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            prev_q <= sample_i;
            if (fill_q != FILL_MAX) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // The write pointer always sits on the oldest entry, so tap k is k slots past it.
    always_comb begin
        taps_o = '0;
        rdIdx = '0;
        for (int k = 0; k < PRE; k++) begin
            rdIdx = {1'b0, wptr_q} + (PTR_W + 1)'(k);
            if (rdIdx >= (PTR_W + 1)'(PRE)) begin
                rdIdx = rdIdx - (PTR_W + 1)'(PRE);
            end
            taps_o[k*IN_WIDTH +: IN_WIDTH] = ring_q[rdIdx[PTR_W-1:0]];
        end
    end

    assign prev_o = prev_q;
    assign full_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/spike_window.sv
// Detects negative-going threshold crossings in the ADC stream and emits a window of
// samples around each one, oldest first, followed by a refractory hold-off.
module spike_window
    import dtree_pkg::*;
#(
    parameter int PRE        = 2,
    parameter int POST       = 1,
    parameter int REFRACTORY = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_valid,
    input  logic [IN_WIDTH-1:0] adc_sample,
    input  logic [IN_WIDTH-1:0] threshold,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IN_WIDTH-1:0] out_sample,
    output logic                out_last,
    output logic [7:0]          missed_count
);

    localparam int WINDOW = PRE + POST;
    localparam int IDX_W = $clog2(WINDOW);
    localparam int CAP_W = (POST > 2) ? $clog2(POST - 1) : 1;
    localparam int REFR_W = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'((POST > 1) ? POST - 2 : 0);
    localparam logic [REFR_W-1:0] REFR_INIT = REFR_W'(REFRACTORY - 1);

    state_t                     state_q;
    logic [WINDOW*IN_WIDTH-1:0] window_q;
    logic [IDX_W-1:0]           idx_q;
    logic [CAP_W-1:0]           cap_q;
    logic [REFR_W-1:0]          refr_q, refr_d;
    logic [7:0]                 missed_q, missed_d;
    logic                       out_valid_q;
    logic [IN_WIDTH-1:0]        out_sample_q;
    logic                       out_last_q;

    logic [PRE*IN_WIDTH-1:0]    histTaps;
    logic [IN_WIDTH-1:0]        histPrev;
    logic                       histFull;
    logic                       crossing;

    sample_history #(.PRE(PRE)) u_history (
        .clk      (clk),
        .reset    (reset),
        .push_i   (adc_valid),
        .sample_i (adc_sample),
        .taps_o   (histTaps),
        .prev_o   (histPrev),
        .full_o   (histFull)
    );

    assign crossing = adc_valid && histFull
                      && ($signed(histPrev) >= $signed(threshold))
                      && ($signed(adc_sample) < $signed(threshold));

    always_comb begin
        refr_d = refr_q;
        if (adc_valid && state_q != ARMED && refr_q != '0) begin
            refr_d = refr_q - 1'b1;
        end
        missed_d = missed_q;
        if (crossing && state_q != ARMED && missed_q != 8'hFF) begin
            missed_d = missed_q + 1'b1;
        end
    end

    // window_q is only written at the trigger and during CAPTURE, so stalls in EMIT never disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARMED;
            window_q     <= '0;
            idx_q        <= '0;
            cap_q        <= '0;
            refr_q       <= '0;
            missed_q     <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            refr_q   <= refr_d;
            missed_q <= missed_d;
            case (state_q)
                ARMED: begin
                    if (crossing) begin
                        window_q[PRE*IN_WIDTH-1:0] <= histTaps;
                        window_q[PRE*IN_WIDTH +: IN_WIDTH] <= adc_sample;
                        refr_q <= REFR_INIT;
                        idx_q  <= '0;
                        cap_q  <= '0;
                        if (POST == 1) begin
                            state_q      <= EMIT;
                            out_valid_q  <= 1'b1;
                            out_sample_q <= histTaps[IN_WIDTH-1:0];
                            out_last_q   <= 1'b0;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (adc_valid) begin
                        window_q[(PRE + 1 + int'(cap_q))*IN_WIDTH +: IN_WIDTH] <= adc_sample;
                        if (cap_q == CAP_LAST) begin
                            state_q      <= EMIT;
                            out_valid_q  <= 1'b1;
                            out_sample_q <= window_q[IN_WIDTH-1:0];
                            out_last_q   <= 1'b0;
                            cap_q        <= '0;
                        end else begin
                            cap_q <= cap_q + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            idx_q       <= '0;
                            state_q     <= (refr_q == '0) ? ARMED : HOLD;
                        end else begin
                            idx_q        <= idx_q + 1'b1;
                            out_sample_q <= window_q[(int'(idx_q) + 1)*IN_WIDTH +: IN_WIDTH];
                            out_last_q   <= ((idx_q + 1'b1) == LAST_IDX);
                        end
                    end
                end
                HOLD: begin
                    if (refr_q == '0) begin
                        state_q <= ARMED;
                    end
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sample   = out_sample_q;
    assign out_last     = out_last_q;
    assign missed_count = missed_q;

endmodule

// File: tb/tb_spike_window.sv
// Directed bench for spike_window: default 3-sample window plus a PRE=4/POST=3 instance.
module tb_spike_window;
    import dtree_pkg::*;

    logic                clk;
    logic                reset;
    logic                adc_valid;
    logic [IN_WIDTH-1:0] adc_sample;
    logic [IN_WIDTH-1:0] threshold;
    logic                out_ready;
    logic                out_valid;
    logic [IN_WIDTH-1:0] out_sample;
    logic                out_last;
    logic [7:0]          missed_count;
    logic                v7_valid;
    logic [IN_WIDTH-1:0] v7_sample;
    logic                v7_last;
    logic [7:0]          v7_missed;

    int checks = 0;
    int passes = 0;

    spike_window dut (
        .clk          (clk),
        .reset        (reset),
        .adc_valid    (adc_valid),
        .adc_sample   (adc_sample),
        .threshold    (threshold),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sample   (out_sample),
        .out_last     (out_last),
        .missed_count (missed_count)
    );

    spike_window #(.PRE(4), .POST(3), .REFRACTORY(8)) dut7 (
        .clk          (clk),
        .reset        (reset),
        .adc_valid    (adc_valid),
        .adc_sample   (adc_sample),
        .threshold    (threshold),
        .out_valid    (v7_valid),
        .out_ready    (out_ready),
        .out_sample   (v7_sample),
        .out_last     (v7_last),
        .missed_count (v7_missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task enters and leaves 1 time unit after a rising edge.
    task automatic applyStimulus(input int v);
        adc_valid = 1'b1;
        adc_sample = IN_WIDTH'(v);
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        adc_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_sample !== '0) $display("[TB] FAIL reset_sample: got %0d want 0", $signed(out_sample)); else passes++;
        checks++; if (out_last !== 1'b0) $display("[TB] FAIL reset_last: got %b want 0", out_last); else passes++;
        checks++; if (missed_count !== 8'd0) $display("[TB] FAIL reset_missed: got %0d want 0", missed_count); else passes++;
        checks++; if (v7_valid !== 1'b0) $display("[TB] FAIL reset_v7_valid: got %b want 0", v7_valid); else passes++;
        reset = 1'b1;
    endtask

    task automatic test_basic_window();
        doReset();
        threshold = '0;
        out_ready = 1'b1;
        applyStimulus(5); applyStimulus(4); applyStimulus(3);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_no_early_valid: got %b want 0", out_valid); else passes++;
        applyStimulus(-2);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(4) || out_last !== 1'b0)
            $display("[TB] FAIL basic_first: got v=%b s=%0d l=%b want v=1 s=4 l=0", out_valid, $signed(out_sample), out_last); else passes++;
        applyStimulus(-7);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(3) || out_last !== 1'b0)
            $display("[TB] FAIL basic_second: got v=%b s=%0d l=%b want v=1 s=3 l=0", out_valid, $signed(out_sample), out_last); else passes++;
        idle(1);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(-2) || out_last !== 1'b1)
            $display("[TB] FAIL basic_last: got v=%b s=%0d l=%b want v=1 s=-2 l=1", out_valid, $signed(out_sample), out_last); else passes++;
        idle(1);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_done: got %b want 0", out_valid); else passes++;
        checks++; if (missed_count !== 8'd0) $display("[TB] FAIL basic_missed: got %0d want 0", missed_count); else passes++;
    endtask

    task automatic test_fill_guard();
        doReset();
        applyStimulus(5); applyStimulus(-1); applyStimulus(6);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL fill_no_trigger: got %b want 0", out_valid); else passes++;
        checks++; if (missed_count !== 8'd0) $display("[TB] FAIL fill_missed: got %0d want 0", missed_count); else passes++;
        applyStimulus(-3);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(-1))
            $display("[TB] FAIL fill_first_window: got v=%b s=%0d want v=1 s=-1", out_valid, $signed(out_sample)); else passes++;
        idle(3);
    endtask

    task automatic test_stall();
        doReset();
        out_ready = 1'b0;
        applyStimulus(5); applyStimulus(4); applyStimulus(3); applyStimulus(-2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(10 + i);
            checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(4) || out_last !== 1'b0)
                $display("[TB] FAIL stall_hold_%0d: got v=%b s=%0d l=%b want v=1 s=4 l=0", i, out_valid, $signed(out_sample), out_last); else passes++;
        end
        out_ready = 1'b1;
        idle(1);
        checks++; if (out_sample !== sample_t'(3) || out_last !== 1'b0)
            $display("[TB] FAIL stall_second: got s=%0d l=%b want s=3 l=0", $signed(out_sample), out_last); else passes++;
        idle(1);
        checks++; if (out_sample !== sample_t'(-2) || out_last !== 1'b1)
            $display("[TB] FAIL stall_last: got s=%0d l=%b want s=-2 l=1", $signed(out_sample), out_last); else passes++;
        idle(1);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stall_done: got %b want 0", out_valid); else passes++;
        applyStimulus(5); applyStimulus(-4);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(19))
            $display("[TB] FAIL stall_rearm: got v=%b s=%0d want v=1 s=19", out_valid, $signed(out_sample)); else passes++;
        idle(3);
    endtask

    task automatic test_refractory();
        doReset();
        applyStimulus(5); applyStimulus(4); applyStimulus(3); applyStimulus(-2);
        applyStimulus(5); applyStimulus(6); applyStimulus(-3);
        checks++; if (missed_count !== 8'd1) $display("[TB] FAIL refr_missed: got %0d want 1", missed_count); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL refr_no_retrigger: got %b want 0", out_valid); else passes++;
        applyStimulus(1); applyStimulus(2); applyStimulus(3); applyStimulus(4);
        applyStimulus(2); applyStimulus(-5);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(4))
            $display("[TB] FAIL refr_new_first: got v=%b s=%0d want v=1 s=4", out_valid, $signed(out_sample)); else passes++;
        idle(1);
        checks++; if (out_sample !== sample_t'(2)) $display("[TB] FAIL refr_new_second: got %0d want 2", $signed(out_sample)); else passes++;
        idle(1);
        checks++; if (out_sample !== sample_t'(-5) || out_last !== 1'b1)
            $display("[TB] FAIL refr_new_last: got s=%0d l=%b want s=-5 l=1", $signed(out_sample), out_last); else passes++;
        checks++; if (missed_count !== 8'd1) $display("[TB] FAIL refr_missed_kept: got %0d want 1", missed_count); else passes++;
        idle(1);
    endtask

    task automatic test_threshold_edge();
        doReset();
        applyStimulus(5); applyStimulus(4); applyStimulus(1); applyStimulus(0);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL thr_equal_not_below: got %b want 0", out_valid); else passes++;
        applyStimulus(-1);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(1))
            $display("[TB] FAIL thr_from_zero: got v=%b s=%0d want v=1 s=1", out_valid, $signed(out_sample)); else passes++;
        idle(1);
        checks++; if (out_sample !== sample_t'(0)) $display("[TB] FAIL thr_second: got %0d want 0", $signed(out_sample)); else passes++;
        idle(1);
        checks++; if (out_sample !== sample_t'(-1) || out_last !== 1'b1)
            $display("[TB] FAIL thr_last: got s=%0d l=%b want s=-1 l=1", $signed(out_sample), out_last); else passes++;
        doReset();
        threshold = IN_WIDTH'(-100);
        applyStimulus(-50); applyStimulus(-60); applyStimulus(-99); applyStimulus(-100);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL thr_neg_equal: got %b want 0", out_valid); else passes++;
        applyStimulus(-101);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(-99))
            $display("[TB] FAIL thr_neg_trigger: got v=%b s=%0d want v=1 s=-99", out_valid, $signed(out_sample)); else passes++;
        threshold = '0;
        idle(3);
    endtask

    task automatic test_reset_mid_window();
        doReset();
        applyStimulus(5); applyStimulus(4); applyStimulus(3); applyStimulus(-2);
        idle(1);
        checks++; if (out_sample !== sample_t'(3)) $display("[TB] FAIL midrst_idx1: got %0d want 3", $signed(out_sample)); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sample !== '0 || out_last !== 1'b0)
            $display("[TB] FAIL midrst_clear: got v=%b s=%0d l=%b want v=0 s=0 l=0", out_valid, $signed(out_sample), out_last); else passes++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(7); applyStimulus(-2); applyStimulus(8);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_refill: got %b want 0", out_valid); else passes++;
        applyStimulus(-3);
        checks++; if (out_valid !== 1'b1 || out_sample !== sample_t'(-2))
            $display("[TB] FAIL midrst_fresh_window: got v=%b s=%0d want v=1 s=-2", out_valid, $signed(out_sample)); else passes++;
        idle(3);
    endtask

    task automatic test_long_window();
        int expSamples [7] = '{20, 30, 40, 50, -1, -2, -3};
        doReset();
        out_ready = 1'b1;
        applyStimulus(10); applyStimulus(20); applyStimulus(30); applyStimulus(40);
        applyStimulus(50); applyStimulus(-1); applyStimulus(-2);
        checks++; if (v7_valid !== 1'b0) $display("[TB] FAIL long_capture_wait: got %b want 0", v7_valid); else passes++;
        applyStimulus(-3);
        checks++; if (v7_valid !== 1'b1) $display("[TB] FAIL long_valid: got %b want 1", v7_valid); else passes++;
        for (int i = 0; i < 7; i++) begin
            checks++; if (v7_sample !== sample_t'(expSamples[i]) || v7_last !== (i == 6))
                $display("[TB] FAIL long_sample_%0d: got s=%0d l=%b want s=%0d l=%b", i, $signed(v7_sample), v7_last, expSamples[i], (i == 6)); else passes++;
            idle(1);
        end
        checks++; if (v7_valid !== 1'b0) $display("[TB] FAIL long_done: got %b want 0", v7_valid); else passes++;
        checks++; if (v7_missed !== 8'd0) $display("[TB] FAIL long_missed: got %0d want 0", v7_missed); else passes++;
    endtask

    initial begin
        reset = 1'b0;
        adc_valid = 1'b0;
        adc_sample = '0;
        threshold = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic_window();
        test_fill_guard();
        test_stall();
        test_refractory();
        test_threshold_edge();
        test_reset_mid_window();
        test_long_window();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
